// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the word-addressed data memory; sub-word stores become read-modify-write.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN selects fixed core-first priority instead of round-robin.
module dmem_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_c_req,
  input  logic        i_c_we,
  input  logic [31:0] i_c_addr,
  input  logic [31:0] i_c_wdata,
  input  logic [3:0]  i_c_bmask,
  output logic        o_c_gnt,
  output logic        o_c_rvalid,
  output logic [31:0] o_c_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_bmask,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_mem_re,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);
  typedef enum logic {IDLE, RMW_WR} state_e;

  state_e      state_q;
  logic [31:0] rmw_addr_q, rmw_data_q;
  logic        c_rvalid_q, d_rvalid_q;
  logic [31:0] c_rdata_q, d_rdata_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic        last_d_q;
`endif

  logic        gnt_c, gnt_d, xfer;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata, merged_d;
  logic [3:0]  sel_bmask;
  logic        rd_go, wr_full, wr_part;

  // Grants are combinational but forced low while reset is asserted.
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (i_rst_n && state_q == IDLE) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      gnt_c = i_c_req;
      gnt_d = i_d_req & ~i_c_req;
`else
      if (i_c_req && i_d_req) begin
        gnt_c = last_d_q;
        gnt_d = ~last_d_q;
      end else begin
        gnt_c = i_c_req;
        gnt_d = i_d_req;
      end
`endif
    end
  end

  assign xfer      = gnt_c | gnt_d;
  assign sel_we    = gnt_c ? i_c_we    : i_d_we;
  assign sel_addr  = (gnt_c ? i_c_addr : i_d_addr) & 32'hFFFF_FFFC;
  assign sel_wdata = gnt_c ? i_c_wdata : i_d_wdata;
  assign sel_bmask = gnt_c ? i_c_bmask : i_d_bmask;

  assign rd_go   = xfer & ~sel_we;
  assign wr_full = xfer & sel_we & (sel_bmask == 4'hF);
  assign wr_part = xfer & sel_we & (sel_bmask != 4'hF) & (sel_bmask != 4'h0);

  always_comb begin
    merged_d = i_mem_rdata;
    for (int k = 0; k < 4; k++)
      if (sel_bmask[k]) merged_d[8*k +: 8] = sel_wdata[8*k +: 8];
  end

  always_comb begin
    o_mem_re    = rd_go | wr_part;
    o_mem_we    = wr_full;
    o_mem_addr  = 32'd0;
    o_mem_wdata = 32'd0;
    if (state_q == RMW_WR) begin
      o_mem_we    = 1'b1;
      o_mem_addr  = rmw_addr_q;
      o_mem_wdata = rmw_data_q;
    end else if (xfer) begin
      o_mem_addr  = sel_addr;
      if (wr_full) o_mem_wdata = sel_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      rmw_addr_q <= 32'd0;
      rmw_data_q <= 32'd0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_d_q   <= 1'b1;
`endif
    end else begin
      c_rvalid_q <= gnt_c & ~i_c_we;
      d_rvalid_q <= gnt_d & ~i_d_we;
      if (gnt_c && !i_c_we) c_rdata_q <= i_mem_rdata;
      if (gnt_d && !i_d_we) d_rdata_q <= i_mem_rdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      if (xfer) last_d_q <= gnt_d;
`endif
      case (state_q)
        IDLE: if (wr_part) begin
          state_q    <= RMW_WR;
          rmw_addr_q <= sel_addr;
          rmw_data_q <= merged_d;
        end
        RMW_WR: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_c_gnt    = gnt_c;
  assign o_d_gnt    = gnt_d;
  assign o_c_rvalid = c_rvalid_q;
  assign o_d_rvalid = d_rvalid_q;
  assign o_c_rdata  = c_rdata_q;
  assign o_d_rdata  = d_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level memory model.
module tb_dmem_arbiter;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_bmask, d_bmask;
  logic        o_c_gnt, o_c_rvalid, o_d_gnt, o_d_rvalid;
  logic [31:0] o_c_rdata, o_d_rdata;
  logic        o_mem_re, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;

  always #5 i_clk = ~i_clk;

  dmem_arbiter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata), .i_c_bmask(c_bmask),
    .o_c_gnt(o_c_gnt), .o_c_rvalid(o_c_rvalid), .o_c_rdata(o_c_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_bmask(d_bmask),
    .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_re(o_mem_re), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  // Memory under the arbiter (environment, not the reference).
  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;
  assign i_mem_rdata = mem[o_mem_addr[7:2]];
  always @(posedge i_clk) begin
    if (pl_en)         mem[pl_idx]          <= pl_val;
    else if (o_mem_we) mem[o_mem_addr[7:2]] <= o_mem_wdata;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
  endtask

  // Reference: memory image plus per-port pending read result and arbitration history.
  logic [31:0] ref_mem [64];
  logic        m_busy, m_last_d, m_c_rv, m_d_rv;
  logic [31:0] m_c_rd, m_d_rd, m_pend_old;
  int          m_pend_idx;

  task automatic model_reset();
    if (m_busy) ref_mem[m_pend_idx] = m_pend_old;
    m_busy = 0; m_last_d = 1; m_c_rv = 0; m_d_rv = 0; m_c_rd = 0; m_d_rd = 0;
  endtask

  task automatic model_cycle();
    logic gc, gd, we, any, exp_re, exp_we;
    logic [31:0] a, wd, w;
    logic [3:0]  bm;
    int idx;
    chk("c_rvalid", o_c_rvalid, m_c_rv); chk("c_rdata", o_c_rdata, m_c_rd);
    chk("d_rvalid", o_d_rvalid, m_d_rv); chk("d_rdata", o_d_rdata, m_d_rd);
    gc = 0; gd = 0;
    if (!m_busy) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      gc = c_req; gd = d_req & ~c_req;
`else
      if (c_req && d_req) begin gc = m_last_d; gd = ~m_last_d; end
      else begin gc = c_req; gd = d_req; end
`endif
    end
    chk("c_gnt", o_c_gnt, gc); chk("d_gnt", o_d_gnt, gd);
    any = gc | gd;
    we = gc ? c_we : d_we; a = gc ? c_addr : d_addr;
    wd = gc ? c_wdata : d_wdata; bm = gc ? c_bmask : d_bmask;
    idx = int'(a[7:2]);
    exp_re = any && (!we || (bm != 4'h0 && bm != 4'hF));
    exp_we = m_busy || (any && we && bm == 4'hF);
    chk("mem_re", o_mem_re, exp_re); chk("mem_we", o_mem_we, exp_we);
    m_c_rv = gc && !we; if (m_c_rv) m_c_rd = ref_mem[idx];
    m_d_rv = gd && !we; if (m_d_rv) m_d_rd = ref_mem[idx];
    m_busy = 0;
    if (any && we) begin
      m_pend_idx = idx; m_pend_old = ref_mem[idx];
      w = ref_mem[idx];
      for (int k = 0; k < 4; k++) if (bm[k]) w[8*k +: 8] = wd[8*k +: 8];
      ref_mem[idx] = w;
      m_busy = (bm != 4'h0) && (bm != 4'hF);
    end
    if (any) m_last_d = gd;
  endtask

  logic        s_c_gnt, s_d_gnt, s_mem_we, s_mem_re;
  logic [31:0] s_mem_addr, s_mem_wdata, s_c_rdata, s_d_rdata;

  task automatic step();
    @(negedge i_clk);
    s_c_gnt = o_c_gnt; s_d_gnt = o_d_gnt; s_mem_we = o_mem_we; s_mem_re = o_mem_re;
    s_mem_addr = o_mem_addr; s_mem_wdata = o_mem_wdata;
    s_c_rdata = o_c_rdata; s_d_rdata = o_d_rdata;
    model_cycle();
    @(posedge i_clk); #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pl_en = 1; pl_idx = idx[5:0]; pl_val = val;
    @(posedge i_clk); #1;
    pl_en = 0; ref_mem[idx] = val;
  endtask

  task automatic set_c(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] bm);
    c_req = 1; c_we = we; c_addr = a; c_wdata = wd; c_bmask = bm;
  endtask
  task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] bm);
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_bmask = bm;
  endtask

  logic [3:0] pat;

  initial begin
    i_rst_n = 0; m_busy = 0;
    model_reset();
    set_c(0, 32'h0, 32'h0, 4'hF);
    set_d(0, 32'h4, 32'h0, 4'hF);
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    preload(0, 32'h1122_3344);
    preload(1, 32'hDEAD_BEEF);
    preload(3, 32'h0);
    // Reset held with both requests high.
    chk("rst_c_gnt", o_c_gnt, 0);    chk("rst_d_gnt", o_d_gnt, 0);
    chk("rst_mem_re", o_mem_re, 0);  chk("rst_mem_we", o_mem_we, 0);
    chk("rst_mem_addr", o_mem_addr, 0); chk("rst_mem_wdata", o_mem_wdata, 0);
    chk("rst_c_rvalid", o_c_rvalid, 0); chk("rst_c_rdata", o_c_rdata, 0);
    chk("rst_d_rvalid", o_d_rvalid, 0); chk("rst_d_rdata", o_d_rdata, 0);
    i_rst_n = 1;
    step();
    chk("first_gnt_core", s_c_gnt, 1);
    c_req = 0;
    step();
    chk("first_rd_data", s_c_rdata, 32'h1122_3344);
    // Continuous contention.
    set_c(0, 32'h0, 32'h0, 4'hF);
    set_d(0, 32'h4, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin step(); pat[i] = s_c_gnt; end
`ifdef DMEM_ARB_FIXED_PRIO_EN
    chk("contend_pattern", pat, 4'b1111);
`else
    chk("contend_pattern", pat, 4'b0101);
`endif
    c_req = 0; d_req = 0;
    // Core store byte into word 1, debug blocked during write-back.
    set_c(1, 32'h5, 32'h0000_AB00, 4'b0010);
    step();
    c_req = 0;
    set_d(0, 32'h4, 32'h0, 4'hF);
    step();
    chk("sb_d_blocked", s_d_gnt, 0);  chk("sb_we", s_mem_we, 1);
    chk("sb_addr", s_mem_addr, 32'h4); chk("sb_wdata", s_mem_wdata, 32'hDEAD_ABEF);
    step();
    chk("sb_d_gnt_after", s_d_gnt, 1);
    d_req = 0;
    step();
    chk("sb_readback", s_d_rdata, 32'hDEAD_ABEF);
    // Debug full write, core reads it back.
    set_d(1, 32'h8, 32'hCAFE_F00D, 4'hF);
    step();
    d_req = 0;
    set_c(0, 32'h8, 32'h0, 4'hF);
    step();
    c_req = 0;
    step();
    chk("fw_readback", s_c_rdata, 32'hCAFE_F00D);
    // Zero-mask write is acknowledged but never reaches memory.
    set_c(1, 32'h4, 32'hFFFF_FFFF, 4'h0);
    step();
    chk("bm0_gnt", s_c_gnt, 1); chk("bm0_we", s_mem_we, 0); chk("bm0_re", s_mem_re, 0);
    c_req = 0;
    step();
    chk("bm0_mem", mem[1], 32'hDEAD_ABEF);
    // Reset during write-back of a halfword store.
    set_c(1, 32'hC, 32'h0000_BEEF, 4'b0011);
    step();
    c_req = 0;
    i_rst_n = 0;
    #1;
    chk("rmw_rst_we", o_mem_we, 0); chk("rmw_rst_addr", o_mem_addr, 0);
    model_reset();
    @(posedge i_clk); #1;
    i_rst_n = 1;
    set_c(0, 32'hC, 32'h0, 4'hF);
    step();
    chk("rmw_rst_idle_gnt", s_c_gnt, 1);
    c_req = 0;
    step();
    chk("rmw_rst_mem", mem[3], 32'h0);
    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      if (!c_req || s_c_gnt) begin
        if ($urandom_range(0, 9) < 7) begin
          case ($urandom_range(0, 3))
            0: set_c(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom, 4'hF);
            1: set_c(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom, 4'h0);
            default: set_c(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom, 4'($urandom_range(1, 14)));
          endcase
        end else c_req = 0;
      end
      if (!d_req || s_d_gnt) begin
        if ($urandom_range(0, 9) < 7) begin
          case ($urandom_range(0, 3))
            0: set_d(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom, 4'hF);
            1: set_d(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom, 4'h0);
            default: set_d(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom, 4'($urandom_range(1, 14)));
          endcase
        end else d_req = 0;
      end
      step();
    end
    c_req = 0; d_req = 0;
    step(); step();
    for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
